// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered EX-stage ALU with start/busy/done handshake
// Define ALU_MUL_EN to build the iterative shift-add multiplier for code 0100.
module alu_exec_unit #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             illegal
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1011;

  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic [31:0]      w_shamt;
  logic             w_ovf, w_ill;

  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_ovf, r_ill, r_done;

  assign w_sum   = A + B;
  assign w_diff  = A - B;
  assign w_shamt = {27'd0, B[4:0]};

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (ALUCtrl)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      // Only B[4:0] is the shift amount; amounts past the word clear it.
      OP_SLL: w_res = (w_shamt >= 32'(WIDTH)) ? '0 : (A << B[4:0]);
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam int         CW     = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (ALUCtrl == OP_MUL)) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MUL;
          end else if (start) begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_ovf    <= w_ovf;
            r_ill    <= w_ill;
            r_done   <= 1'b1;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // Last iteration: publish straight from the next accumulator value.
          if (r_cnt == CW'(WIDTH-1)) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
            r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_ill    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
`else
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_done <= start;
      if (start) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
        r_ill    <= w_ill;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign done     = r_done;
  assign Result   = r_result;
  assign Zero     = r_zero;
  assign Overflow = r_ovf;
  assign illegal  = r_ill;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
// Arithmetic model plus per-cycle compare and directed literal checks.
module tb_alu_exec_unit;
  localparam int WIDTH = 24;

  logic             Clock, Reset, start;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, Zero, Overflow, illegal;
  logic [WIDTH-1:0] Result;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .ALUCtrl(ALUCtrl),
    .A(A), .B(B), .busy(busy), .done(done), .Result(Result),
    .Zero(Zero), .Overflow(Overflow), .illegal(illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] r;
    bit               o;
    bit               il;
  } ent_t;

  ent_t             q[$];
  int               cyc      = 0;
  int               mul_edge = -1000;
  bit               e_done   = 1'b0;
  bit               e_busy   = 1'b0;
  logic [WIDTH-1:0] e_res    = '0;
  bit               e_zero   = 1'b1;
  bit               e_ovf    = 1'b0;
  bit               e_ill    = 1'b0;

  function automatic void model(input logic [3:0] op, input logic [WIDTH-1:0] a, b,
                                output logic [WIDTH-1:0] r, output bit o, output bit il,
                                output bit m);
    longint sa, sb, s, p, smax, smin;
    int     sh;
    sa = longint'(a);
    sb = longint'(b);
    if (a[WIDTH-1]) sa = sa - (longint'(1) << WIDTH);
    if (b[WIDTH-1]) sb = sb - (longint'(1) << WIDTH);
    smax = (longint'(1) << (WIDTH-1)) - 1;
    smin = -(longint'(1) << (WIDTH-1));
    r = '0; o = 1'b0; il = 1'b0; m = 1'b0;
    case (op)
      4'b0010: begin s = sa + sb; r = s[WIDTH-1:0]; o = (s > smax) || (s < smin); end
      4'b1010: begin s = sa - sb; r = s[WIDTH-1:0]; o = (s > smax) || (s < smin); end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0101: r = a ^ b;
      4'b1011: r = (sa < sb) ? 1 : 0;
      4'b0110: begin
        sh = int'(b) % 32;
        if (sh < WIDTH) begin
          p = longint'(a) * (longint'(1) << sh);
          r = p[WIDTH-1:0];
        end
      end
`ifdef ALU_MUL_EN
      4'b0100: begin
        p = longint'(a) * longint'(b);
        r = p[WIDTH-1:0];
        o = (p >> WIDTH) != 0;
        m = 1'b1;
      end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Edge-indexed model: a start accepted at edge n is due at edge n (or n+WIDTH for MUL).
  always @(posedge Clock) begin
    logic [WIDTH-1:0] r;
    bit               o, il, m;
    ent_t             en;
    cyc    = cyc + 1;
    e_done = 1'b0;
    if (Reset) begin
      q.delete();
      mul_edge = -1000;
      e_busy = 1'b0; e_res = '0; e_zero = 1'b1; e_ovf = 1'b0; e_ill = 1'b0;
    end else begin
      if (start && !((cyc-1 >= mul_edge) && (cyc-1 <= mul_edge + WIDTH - 1))) begin
        model(ALUCtrl, A, B, r, o, il, m);
        en.r = r; en.o = o; en.il = il;
        en.due = m ? cyc + WIDTH : cyc;
        if (m) mul_edge = cyc;
        q.push_back(en);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        en = q.pop_front();
        e_done = 1'b1; e_res = en.r; e_zero = (en.r == '0); e_ovf = en.o; e_ill = en.il;
      end
      e_busy = (cyc >= mul_edge) && (cyc <= mul_edge + WIDTH - 1);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_cycle();
    check("done", 64'(done), 64'(e_done));
    check("busy", 64'(busy), 64'(e_busy));
    check("Result", 64'(Result), 64'(e_res));
    check("Zero", 64'(Zero), 64'(e_zero));
    check("Overflow", 64'(Overflow), 64'(e_ovf));
    check("illegal", 64'(illegal), 64'(e_ill));
  endtask

  task automatic tick();
    @(negedge Clock);
    compare_cycle();
  endtask

  task automatic op(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1; ALUCtrl = c; A = a; B = b;
    tick();
    start = 1'b0;
  endtask

  localparam logic [3:0] C_ADD = 4'b0010, C_SUB = 4'b1010, C_SLT = 4'b1011;
  localparam logic [3:0] C_SLL = 4'b0110, C_MUL = 4'b0100, C_OR = 4'b0001;

  logic [3:0]       vc [8] = '{4'b0000, 4'b0001, 4'b0101, 4'b0010, 4'b1010, 4'b1011, 4'b0110, 4'b1100};
  logic [WIDTH-1:0] va [8] = '{24'hF0F0F0, 24'h00FF00, 24'hAAAAAA, 24'h800000, 24'h800000, 24'h000005, 24'h00ABCD, 24'h123456};
  logic [WIDTH-1:0] vb [8] = '{24'h0FF0FF, 24'h0F0F0F, 24'hFFFFFF, 24'h800000, 24'h000001, 24'hFFFFFE, 24'h000028, 24'h000001};

  initial begin
    logic [WIDTH-1:0] r;
    bit               o, il, m;
    int               cnt, bcnt, dcnt;

    Reset = 1'b1; start = 1'b0; ALUCtrl = '0; A = '0; B = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("reset_Result", 64'(Result), 64'h0);
    check("reset_Zero", 64'(Zero), 64'h1);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    model(C_ADD, 24'h7FFFFF, 24'h000001, r, o, il, m);
    check("model_add", {39'd0, o, r}, {39'd0, 1'b1, 24'h800000});
    model(C_SLT, 24'hFFFFFF, 24'h000001, r, o, il, m);
    check("model_slt", 64'(r), 64'h1);
    model(C_SLL, 24'h000001, 24'd24, r, o, il, m);
    check("model_sll24", 64'(r), 64'h0);
`ifdef ALU_MUL_EN
    model(C_MUL, 24'h000123, 24'h000456, r, o, il, m);
    check("model_mul", {39'd0, o, r}, {39'd0, 1'b0, 24'h04EDC2});
`endif

    op(C_ADD, 24'h7FFFFF, 24'h000001);
    check("add_done", 64'(done), 64'h1);
    check("add_res", 64'(Result), 64'h800000);
    check("add_ovf", 64'(Overflow), 64'h1);
    op(C_SUB, 24'd5, 24'd5);
    check("sub_res", 64'(Result), 64'h0);
    check("sub_zero", 64'(Zero), 64'h1);
    op(C_SLT, 24'hFFFFFF, 24'h000001);
    check("slt_res", 64'(Result), 64'h1);
    op(C_SLL, 24'h000001, 24'd23);
    check("sll23_res", 64'(Result), 64'h800000);
    op(C_SLL, 24'h000001, 24'd24);
    check("sll24_res", 64'(Result), 64'h0);
    op(C_SLL, 24'h000001, 24'd32);
    check("sll32_res", 64'(Result), 64'h1);
    op(4'b1111, 24'h123456, 24'h654321);
    check("ill_flag", 64'(illegal), 64'h1);
    check("ill_res", 64'(Result), 64'h0);
    repeat (2) tick();
    check("hold_ill", 64'(illegal), 64'h1);

    start = 1'b1; ALUCtrl = C_ADD; A = 24'd10; B = 24'd20;
    tick();
    ALUCtrl = C_OR; A = 24'h0F0000; B = 24'h0000F0;
    tick();
    start = 1'b0;
    check("b2b_res", 64'(Result), 64'h0F00F0);
    check("b2b_done", 64'(done), 64'h1);

    for (int i = 0; i < 8; i++) begin
      op(vc[i], va[i], vb[i]);
      if (i % 2 == 1) tick();
    end

`ifdef ALU_MUL_EN
    op(C_MUL, 24'h000123, 24'h000456);
    cnt  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && cnt < 40) begin
      if (cnt == 5) begin start = 1'b1; ALUCtrl = C_ADD; A = 24'd1; B = 24'd2; end
      tick();
      start = 1'b0;
      cnt++;
      if (busy) bcnt++;
    end
    check("mul_latency", 64'(cnt), 64'd25);
    check("mul_busy_cycles", 64'(bcnt), 64'd24);
    check("mul_res", 64'(Result), 64'h04EDC2);
    check("mul_ovf", 64'(Overflow), 64'h0);
    op(C_ADD, 24'd3, 24'd4);
    check("add_after_mul_done", 64'(done), 64'h1);
    check("add_after_mul_res", 64'(Result), 64'h7);

    op(C_MUL, 24'h001000, 24'h001000);
    cnt = 1;
    while (!done && cnt < 40) begin tick(); cnt++; end
    check("mul2_latency", 64'(cnt), 64'd25);
    check("mul2_res", 64'(Result), 64'h0);
    check("mul2_ovf", 64'(Overflow), 64'h1);

    op(C_MUL, 24'h000777, 24'h000333);
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    dcnt = 0;
    repeat (30) begin tick(); if (done) dcnt++; end
    check("abort_no_done", 64'(dcnt), 64'd0);
`else
    op(C_MUL, 24'h000123, 24'h000456);
    check("nomul_done", 64'(done), 64'h1);
    check("nomul_ill", 64'(illegal), 64'h1);
    check("nomul_res", 64'(Result), 64'h0);
    bcnt = 0;
    repeat (5) begin tick(); if (busy) bcnt++; end
    check("nomul_busy", 64'(bcnt), 64'd0);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered 24-bit execution unit on the consuming side of the `ALUCtrl` interface. It takes the 4-bit ALU control code produced by ALU control decode, plus two operands, and executes the operation. Most operations finish in one cycle. `MUL` runs an iterative shift-add sequence. Sits in the EX stage of the 24-bit CPU and gives the controller a start/busy/done handshake so EX can stall on multi-cycle ops.

## Interface
Parameters:
- `WIDTH`, 24, operand/result width.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `ALUCtrl`  in  4  operation code.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `busy`  out  1  multiply in progress; new starts are ignored.
- `done`  out  1  one-cycle pulse; `Result` and flags are valid.
- `Result`  out  WIDTH  operation result, held until the next `done`.
- `Zero`  out  1  `Result`==0; used by BEQ/BNE.
- `Overflow`  out  1  signed overflow (ADD/SUB) or product high half nonzero (MUL).
- `illegal`  out  1  unsupported code; valid with `done`.

## Operation
- Codes:
  - 0010 ADD: A+B.
  - 1010 SUB: A−B.
  - 0000 AND.
  - 0001 OR.
  - 0101 XOR.
  - 1011 SLT: signed A<B gives 1, else 0.
  - 0110 SLL: A<<B[4:0]; a shift amount ≥ WIDTH gives 0.
  - 0100 MUL: unsigned; `Result` = low WIDTH bits of the product.
- Any other code: `Result`=0, `illegal`=1, `Overflow`=0.
- States: IDLE, MUL.
- IDLE:
  - `start`=1 with a non-MUL code: compute and register outputs, pulse `done`, stay in IDLE.
  - `start`=1 with MUL: latch A (multiplicand), B (multiplier), clear the 2·WIDTH accumulator and the iteration counter, go to MUL.
- MUL:
  - Each cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Then shift the multiplicand left and the multiplier right, and increment the counter.
  - After WIDTH iterations: register `Result`/flags, pulse `done`, return to IDLE.
- `Overflow`:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - MUL: product[2·WIDTH−1:WIDTH] ≠ 0.
  - All others: 0.
- `Zero` is registered with `Result`. `Result`, `Zero`, `Overflow` and `illegal` hold between `done` pulses.
- Operand or `ALUCtrl` changes while `busy`=1 have no effect; the operands are latched.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `Result`=0, `Zero`=1, `Overflow`=0, `illegal`=0, counter=0.
- Reset during MUL aborts the operation. No `done` is issued.
- Non-MUL: `start` sampled at edge n gives `done`=1 in cycle n+1. Latency 1, throughput 1 per cycle with back-to-back starts.
- MUL: `start` sampled at edge n gives `busy`=1 in cycles n+1..n+WIDTH and `done`=1 with `busy`=0 in cycle n+WIDTH+1. Latency WIDTH+1 = 25.
- A `start` in the `done` cycle of a MUL is accepted (`busy`=0 there).
- `start`=1 while `busy`=1 is dropped, not queued.
- `done` is never asserted for more than one consecutive cycle unless consecutive starts are accepted.

## Configuration
- `ALU_MUL_EN` defined: the MUL state, counter and accumulator are built, and 0100 behaves as above.
- `ALU_MUL_EN` undefined:
  - No multiplier hardware is built.
  - 0100 is treated as illegal: `Result`=0, `illegal`=1, latency 1.
  - `busy` is tied to 0.

## Test plan
- Reset, then idle: `Result`=0, `Zero`=1, `busy`=0, `done`=0. Assert `Reset` during MUL cycle 10: no `done`, state IDLE next cycle.
- ADD 0x7FFFFF+0x000001 → `Result`=0x800000, `Overflow`=1, `done` 1 cycle later. SUB 5−5 → `Result`=0, `Zero`=1.
- SLT A=0xFFFFFF (−1), B=0x000001 → `Result`=1. SLL A=1, B=23 → 0x800000. SLL A=1, B=24 → 0.
- MUL 0x000123×0x000456 → `Result`=0x04EDC2 (low 24 bits of 0x4EDC2), `Overflow`=0. `done` exactly 25 cycles after `start`, `busy` high for 24 cycles. MUL 0x001000×0x001000 → `Result`=0, `Overflow`=1.
- `start` with ADD while `busy` → ignored. `start` with ADD in the MUL `done` cycle → accepted, ADD `done` on the next cycle.
- Code 1111 → `illegal`=1, `Result`=0. Without `ALU_MUL_EN`, code 0100 → `illegal`=1, `busy` never asserted.
